// File: rtl/win_rf_pkg.sv
// Shared sizing for the windowed register file, its controller and datapath.
// Derived widths live here so every consumer agrees on pointer and index sizes.
package win_rf_pkg;

    localparam int DATA_W     = 16;
    localparam int LADDR_W    = 2;
    localparam int NUM_WIN    = 4;
    localparam int WIN_STRIDE = 2;

    localparam int PHYS    = NUM_WIN * WIN_STRIDE;
    localparam int WPTR_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int PADDR_W = (PHYS > 1) ? $clog2(PHYS) : 1;

endpackage

// File: rtl/window_addr_map.sv
// Maps a logical register address in the current window onto the physical ring.
// The ring wraps, so high windows reuse the low physical registers.
module window_addr_map
    import win_rf_pkg::*;
(
    input  logic [WPTR_W-1:0]  win_ptr,
    input  logic [LADDR_W-1:0] laddr,
    output logic [PADDR_W-1:0] phys
);

    localparam int SUM_W = WPTR_W + LADDR_W + $clog2(WIN_STRIDE + 1) + 1;

    logic [SUM_W-1:0] sum;

    assign sum  = SUM_W'(win_ptr) * SUM_W'(WIN_STRIDE) + SUM_W'(laddr);
    assign phys = PADDR_W'(sum % SUM_W'(PHYS));

endmodule

// File: rtl/window_reg_file.sv
// Windowed register file: ring of physical registers viewed through a window pointer.
// Two combinational read ports, one synchronous write port, no write-to-read bypass.
module window_reg_file
    import win_rf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic               win_update,
    input  logic [WPTR_W-1:0]  win_sel,
    input  logic [LADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [LADDR_W-1:0] rd_addr_a,
    input  logic [LADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b,
    output logic [WPTR_W-1:0]  win_ptr
);

    if (2 ** LADDR_W > PHYS) begin : g_size_chk
        $error("window_reg_file: logical space larger than physical ring");
    end

    localparam logic [WPTR_W:0] NWIN = (WPTR_W + 1)'(NUM_WIN);

    logic [DATA_W-1:0]  regs [PHYS];
    logic [PADDR_W-1:0] phys_a;
    logic [PADDR_W-1:0] phys_b;
    logic [PADDR_W-1:0] phys_w;
    logic [WPTR_W:0]    sel_ext;
    logic [WPTR_W-1:0]  next_ptr;

    window_addr_map u_map_a (
        .win_ptr (win_ptr),
        .laddr   (rd_addr_a),
        .phys    (phys_a)
    );

    window_addr_map u_map_b (
        .win_ptr (win_ptr),
        .laddr   (rd_addr_b),
        .phys    (phys_b)
    );

    window_addr_map u_map_w (
        .win_ptr (win_ptr),
        .laddr   (wr_addr),
        .phys    (phys_w)
    );

    // Fold out-of-range selects back into the ring when NUM_WIN is not a power of two
    assign sel_ext  = {1'b0, win_sel};
    assign next_ptr = WPTR_W'(sel_ext % NWIN);

    // Write address comes from the pre-update pointer when both strobes fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_ptr <= '0;
            for (int i = 0; i < PHYS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write_en) begin
                regs[phys_w] <= wr_data;
            end
            if (win_update) begin
                win_ptr <= next_ptr;
            end
        end
    end

    assign rd_data_a = regs[phys_a];
    assign rd_data_b = regs[phys_b];

endmodule

// File: tb/tb_window_reg_file.sv
// Directed bench for window_reg_file: vector table plus reset and same-cycle sequences.
// Expected values are hand-derived from the ring mapping (win*2 + laddr) mod 8.
module tb_window_reg_file;
    import win_rf_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               write_en = 1'b0;
    logic               win_update = 1'b0;
    logic [WPTR_W-1:0]  win_sel = '0;
    logic [LADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0]  wr_data = '0;
    logic [LADDR_W-1:0] rd_addr_a = '0;
    logic [LADDR_W-1:0] rd_addr_b = '0;
    logic [DATA_W-1:0]  rd_data_a;
    logic [DATA_W-1:0]  rd_data_b;
    logic [WPTR_W-1:0]  win_ptr;

    int n_cmp = 0;
    int n_bad = 0;

    window_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .win_update (win_update),
        .win_sel    (win_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .win_ptr    (win_ptr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(write_en) && !$isunknown(win_update))
                else $error("X on write_en/win_update");
        end
    end

    typedef struct {
        logic              we;
        logic              wu;
        logic [1:0]        sel;
        logic [1:0]        wa;
        logic [15:0]       wd;
        logic [1:0]        ra;
        logic [1:0]        rb;
        logic [15:0]       exp_a;
        logic [15:0]       exp_b;
        logic [1:0]        exp_ptr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        write_en   = v.we;
        win_update = v.wu;
        win_sel    = v.sel;
        wr_addr    = v.wa;
        wr_data    = v.wd;
        rd_addr_a  = v.ra;
        rd_addr_b  = v.rb;
    endtask

    task automatic idle();
        write_en   = 1'b0;
        win_update = 1'b0;
    endtask

    initial begin
        // we wu sel wa wd ra rb exp_a exp_b ptr
        vecs[0]  = '{1, 0, 0, 2, 16'hBEEF, 2, 0, 16'hBEEF, 16'h0000, 0};
        vecs[1]  = '{1, 0, 0, 3, 16'h1234, 3, 2, 16'h1234, 16'hBEEF, 0};
        vecs[2]  = '{0, 1, 1, 0, 16'h0000, 1, 0, 16'h1234, 16'hBEEF, 1};
        vecs[3]  = '{0, 1, 3, 0, 16'h0000, 3, 1, 16'h0000, 16'h0000, 3};
        vecs[4]  = '{1, 0, 0, 3, 16'hA5A5, 3, 0, 16'hA5A5, 16'h0000, 3};
        vecs[5]  = '{0, 1, 0, 0, 16'h0000, 1, 2, 16'hA5A5, 16'hBEEF, 0};
        vecs[6]  = '{1, 1, 2, 0, 16'h0042, 0, 1, 16'h0000, 16'h0000, 2};
        vecs[7]  = '{0, 1, 0, 0, 16'h0000, 0, 3, 16'h0042, 16'h1234, 0};
        vecs[8]  = '{1, 0, 0, 1, 16'h7777, 1, 1, 16'h7777, 16'h7777, 0};
        vecs[9]  = '{1, 1, 2, 3, 16'h3333, 1, 0, 16'h0000, 16'h0000, 2};
        vecs[10] = '{0, 1, 1, 0, 16'h0000, 1, 0, 16'h3333, 16'hBEEF, 1};
        vecs[11] = '{1, 0, 0, 0, 16'hFFFF, 0, 2, 16'hFFFF, 16'h0000, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rd_a", 32'(rd_data_a), 32'h0);
        check("reset_ptr", 32'(win_ptr), 32'h0);

        // Same-cycle read sees the old value until the edge
        @(negedge clk);
        write_en  = 1'b1;
        wr_addr   = 2'd2;
        wr_data   = 16'hBEEF;
        rd_addr_a = 2'd2;
        #1;
        check("pre_edge_read", 32'(rd_data_a), 32'h0000);
        @(posedge clk);
        #1;
        check("post_edge_read", 32'(rd_data_a), 32'hBEEF);
        idle();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd_a", i), 32'(rd_data_a), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_rd_b", i), 32'(rd_data_b), 32'(vecs[i].exp_b));
            check($sformatf("vec%0d_ptr", i), 32'(win_ptr), 32'(vecs[i].exp_ptr));
            idle();
        end

        // Async reset between edges, with a write and window update pending
        @(negedge clk);
        write_en   = 1'b1;
        win_update = 1'b1;
        win_sel    = 2'd3;
        wr_addr    = 2'd0;
        wr_data    = 16'hDEAD;
        rd_addr_a  = 2'd0;
        rd_addr_b  = 2'd3;
        #1;
        check("pre_rst_rd_a", 32'(rd_data_a), 32'hFFFF);
        rst = 1'b1;
        #1;
        check("async_rst_rd_a", 32'(rd_data_a), 32'h0);
        check("async_rst_rd_b", 32'(rd_data_b), 32'h0);
        check("async_rst_ptr", 32'(win_ptr), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_ptr", 32'(win_ptr), 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_addr_a = 2'(a);
            #1;
            check($sformatf("post_rst_r%0d", a), 32'(rd_data_a), 32'h0);
        end

        // Window 0 registers seen through windows 1 and 3 after reset
        @(negedge clk);
        write_en  = 1'b1;
        wr_addr   = 2'd1;
        wr_data   = 16'h5A5A;
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        win_update = 1'b1;
        win_sel    = 2'd3;
        rd_addr_a  = 2'd3;
        rd_addr_b  = 2'd2;
        @(posedge clk);
        #1;
        idle();
        check("wrap_alias_r3", 32'(rd_data_a), 32'h5A5A);
        check("wrap_r2_phys0", 32'(rd_data_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
